// File: rtl/timer_dev_pkg.sv
// Shared definitions for the bridge-attached timer devices: register map,
// CTRL layout, mode and FSM encodings, and device base-address tags.
package timer_dev_pkg;

   localparam logic [1:0] RegCtrl   = 2'd0;
   localparam logic [1:0] RegPreset = 2'd1;
   localparam logic [1:0] RegCount  = 2'd2;

   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlModeLsb = 1;
   localparam int unsigned CtrlModeMsb = 2;
   localparam int unsigned CtrlImBit   = 3;

   localparam logic [1:0] ModeOneShot  = 2'b00;
   localparam logic [1:0] ModePeriodic = 2'b01;

   // Bits [31:4] of each device's base address
   localparam logic [27:0] Dev0Tag = 28'h00007F0;
   localparam logic [27:0] Dev1Tag = 28'h00007F1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StCnt  = 2'd2,
      StInt  = 2'd3
   } timer_state_e;

   // Packed so that bit 3 = IM, [2:1] = Mode, bit 0 = En
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

   // Modes 10 and 11 fall back to one-shot behaviour
   function automatic logic is_periodic(input logic [1:0] mode);
      return mode == ModePeriodic;
   endfunction

endpackage

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counter timer responding on the bridge device bus,
// with one-shot / periodic modes and a maskable level interrupt.
module timer_dev
   import timer_dev_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:2]  dev_addr,
   input  logic [31:0] dev_wd,
   input  logic        we,
   output logic [31:0] dev_rd,
   output logic        irq
);

   ctrl_t        ctrl_q;
   logic [31:0]  preset_q;
   logic [31:0]  count_q;
   timer_state_e state_q;
   logic         irq_flag_q;

   logic ctrl_wr;
   logic preset_wr;
   logic periodic;
   logic flag_set;
   logic flag_clr;

   assign periodic  = is_periodic(ctrl_q.mode);
   assign ctrl_wr   = we && (dev_addr == RegCtrl);
   assign preset_wr = we && (dev_addr == RegPreset);

   // A set on this edge takes priority over any clear so no event is dropped
   assign flag_set = (state_q == StCnt) && ctrl_q.en && (count_q == '0);
   assign flag_clr = ((ctrl_wr || preset_wr) && !periodic) || ((state_q == StInt) && periodic);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         state_q    <= StIdle;
         irq_flag_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ctrl_q.en) state_q <= StLoad;
            end
            StLoad: begin
               count_q <= preset_q;
               state_q <= StCnt;
            end
            StCnt: begin
               if (!ctrl_q.en) begin
                  state_q <= StIdle;
               end else if (count_q == '0) begin
                  state_q <= StInt;
               end else begin
                  count_q <= count_q - 32'd1;
               end
            end
            StInt: begin
               if (periodic) begin
                  state_q <= StLoad;
               end else begin
                  ctrl_q.en <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (flag_set) begin
            irq_flag_q <= 1'b1;
         end else if (flag_clr) begin
            irq_flag_q <= 1'b0;
         end

         // Placed after the FSM so a software CTRL write overrides the En clear
         if (ctrl_wr)   ctrl_q   <= ctrl_t'(dev_wd[3:0]);
         if (preset_wr) preset_q <= dev_wd;
      end
   end

   always_comb begin
      dev_rd = '0;
      case (dev_addr)
         RegCtrl:   dev_rd = {28'b0, ctrl_q};
         RegPreset: dev_rd = preset_q;
         RegCount:  dev_rd = count_q;
         default:   dev_rd = '0;
      endcase
   end

   assign irq = ctrl_q.im & irq_flag_q;

endmodule
